gb_host_arb: RTL and testbench
==============================

GB_HOST_ARB -- requirements
Module: gb_host_arb

Interface
REQ-001 The block SHALL have parameter AW, default 24, meaning bus address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning bus data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, legal range 1..15, meaning ghostbus read latency in cycles from read strobe to valid gb_rdata.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 a_req  input  1  requester A transaction request, held until a_ack.
REQ-008 a_we  input  1  requester A write (1) / read (0).
REQ-009 a_addr  input  AW  requester A address.
REQ-010 a_wdata  input  DW  requester A write data.
REQ-011 a_ack  output  1  one-cycle completion pulse to A.
REQ-012 a_rdata  output  DW  read data to A, valid with a_ack.
REQ-013 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata SHALL mirror REQ-007..REQ-012 for requester B.
REQ-014 gb_addr  output  AW  ghostbus address.
REQ-015 gb_wdata  output  DW  ghostbus write data.
REQ-016 gb_we  output  1  ghostbus write strobe.
REQ-017 gb_re  output  1  ghostbus read strobe.
REQ-018 gb_rdata  input  DW  ghostbus read data.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK.
REQ-020 IDLE: if a_req or b_req is high, the block SHALL latch the winner's we/addr/wdata and the winner id, then enter ISSUE; otherwise remain in IDLE.
REQ-021 Arbitration SHALL be round-robin: sole requester wins; if both are high, the requester other than the last-granted one wins.
REQ-022 ISSUE (cycle T): gb_we (write) or gb_re (read) SHALL be high for exactly this one cycle, with gb_addr/gb_wdata driven from the latched values.
REQ-023 From ISSUE, a write SHALL go to ACK; a read SHALL load a 4-bit counter with RD_LAT and go to WAIT.
REQ-024 WAIT SHALL decrement the counter each cycle; in cycle T+RD_LAT the block SHALL capture gb_rdata into the winner's rdata register and go to ACK.
REQ-025 ACK SHALL pulse the winner's ack for one cycle (write: cycle T+1; read: cycle T+RD_LAT+1), update last-granted, and return to IDLE.
REQ-026 The winner's rdata SHALL be stable and valid during its ack; the non-winner's rdata SHALL not change.
REQ-027 a_rdata/b_rdata SHALL hold their last captured value until the next read completion for that requester; writes SHALL not alter them.
REQ-028 gb_addr/gb_wdata SHALL hold the last latched values outside ISSUE; gb_we/gb_re SHALL be 0 outside ISSUE.
REQ-029 Requests SHALL be sampled only in IDLE; req changes during ISSUE/WAIT/ACK SHALL be ignored, and a granted transaction SHALL complete and ack even if its req drops.
REQ-030 A req still high in the cycle after its ack SHALL be treated as a new request (earliest next ISSUE: ACK+2).
REQ-031 gb_we and gb_re SHALL never be high simultaneously; at most one ack SHALL be high per cycle.

Reset
REQ-032 While rst_n=0 at a rising edge: state IDLE, counter 0, gb_we=gb_re=0, gb_addr=gb_wdata=0, a_ack=b_ack=0, a_rdata=b_rdata=0, last-granted=B (A wins the first tie).
REQ-033 Reset in any state SHALL abort the transaction with no ack issued and no further bus strobe.

Verification
REQ-034 A write addr 0x000004 data 0xceceface, B idle -> gb_we=1 for one cycle T with those values; a_ack=1 at T+1 only.
REQ-035 RD_LAT=2, B read addr 0x000100, gb_rdata=0x000000cc at T+2 -> gb_re one cycle at T; b_ack at T+3 with b_rdata=0x000000cc; a_rdata unchanged.
REQ-036 After reset, a_req and b_req held high continuously -> grants in order A, B, A, B; never two acks in one cycle.
REQ-037 rst_n=0 during WAIT of an A read -> next cycle all outputs at reset values; no a_ack ever for that read.
REQ-038 A write, a_req dropped at T -> a_ack still at T+1; no second transaction issued.

Source files
------------

// File: rtl/gb_host_arb_if.sv
// Requester A/B handshakes plus the ghostbus side of the host arbiter.
// slave = arbiter view, master = requesters and ghostbus target view.
interface gb_host_arb_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_we;
  logic          gb_re;
  logic [DW-1:0] gb_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  gb_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output gb_addr, gb_wdata, gb_we, gb_re
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output gb_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  gb_addr, gb_wdata, gb_we, gb_re
  );
endinterface

// File: rtl/gb_host_arb.sv
// Two-requester round-robin arbiter onto a single-outstanding ghostbus.
// One transaction at a time: IDLE grant -> ISSUE strobe -> (WAIT read latency) -> ACK.
module gb_host_arb #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  gb_host_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [3:0]    r_cnt;
  logic          r_win_b;
  logic          r_last_b;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  logic          w_win_b;
  logic          w_grant;
  logic          w_load;
  logic          w_dec;
  logic          w_cap;
  logic          w_done;

  // Tie goes to whoever was not served last; r_last_b resets to B so A wins first.
  assign w_win_b = bus.b_req & (~bus.a_req | ~r_last_b);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_grant = 1'b0;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    w_cap   = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.a_req | bus.b_req) begin
          w_grant = 1'b1;
          w_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_nxt = ACK;
        end else begin
          w_load = 1'b1;
          w_nxt  = WAIT;
        end
      end
      WAIT: begin
        w_dec = 1'b1;
        // Counter holds 1 in cycle T+RD_LAT, the cycle gb_rdata is valid.
        if (r_cnt == 4'd1) begin
          w_cap = 1'b1;
          w_nxt = ACK;
        end
      end
      ACK: begin
        w_done = 1'b1;
        w_nxt  = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_win_b   <= 1'b0;
      r_last_b  <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_win_b <= w_win_b;
        r_we    <= w_win_b ? bus.b_we    : bus.a_we;
        r_addr  <= w_win_b ? bus.b_addr  : bus.a_addr;
        r_wdata <= w_win_b ? bus.b_wdata : bus.a_wdata;
      end
      if (w_load)
        r_cnt <= 4'(RD_LAT);
      else if (w_dec)
        r_cnt <= r_cnt - 4'd1;
      if (w_cap) begin
        if (r_win_b) r_b_rdata <= bus.gb_rdata;
        else         r_a_rdata <= bus.gb_rdata;
      end
      if (w_done)
        r_last_b <= r_win_b;
    end
  end

  assign bus.gb_addr  = r_addr;
  assign bus.gb_wdata = r_wdata;
  assign bus.gb_we    = (r_state == ISSUE) &  r_we;
  assign bus.gb_re    = (r_state == ISSUE) & ~r_we;
  assign bus.a_ack    = (r_state == ACK) & ~r_win_b;
  assign bus.b_ack    = (r_state == ACK) &  r_win_b;
  assign bus.a_rdata  = r_a_rdata;
  assign bus.b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_gb_host_arb.sv
// Directed checks of gb_host_arb with RD_LAT=2: reset, write, read latency,
// reset abort mid-read and round-robin under continuous contention.
module tb_gb_host_arb;
  localparam int AW = 24;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gb_host_arb_if #(.AW(AW), .DW(DW)) bus ();

  gb_host_arb #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_outs(input string pfx);
    chk({pfx, "_gb_we"},    bus.gb_we,    0);
    chk({pfx, "_gb_re"},    bus.gb_re,    0);
    chk({pfx, "_gb_addr"},  bus.gb_addr,  0);
    chk({pfx, "_gb_wdata"}, bus.gb_wdata, 0);
    chk({pfx, "_a_ack"},    bus.a_ack,    0);
    chk({pfx, "_b_ack"},    bus.b_ack,    0);
    chk({pfx, "_a_rdata"},  bus.a_rdata,  0);
    chk({pfx, "_b_rdata"},  bus.b_rdata,  0);
  endtask

  int grants[4];
  int ngr;

  initial begin
    rst_n        = 1'b0;
    bus.a_req    = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req    = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.gb_rdata = 32'hdeadbeef;

    // Reset state
    tick(); tick();
    chk_rst_outs("rst");
    rst_n = 1'b1;

    // A write, B idle; A drops req during ISSUE
    bus.a_req = 1'b1; bus.a_we = 1'b1;
    bus.a_addr = 24'h000004; bus.a_wdata = 32'hceceface;
    tick();
    chk("wr_T_gb_we",    bus.gb_we,    1);
    chk("wr_T_gb_re",    bus.gb_re,    0);
    chk("wr_T_gb_addr",  bus.gb_addr,  24'h000004);
    chk("wr_T_gb_wdata", bus.gb_wdata, 32'hceceface);
    chk("wr_T_a_ack",    bus.a_ack,    0);
    bus.a_req = 1'b0;
    tick();
    chk("wr_T1_a_ack",   bus.a_ack,    1);
    chk("wr_T1_gb_we",   bus.gb_we,    0);
    chk("wr_T1_gb_addr", bus.gb_addr,  24'h000004);
    tick();
    chk("wr_T2_a_ack",   bus.a_ack,    0);
    tick();
    chk("wr_T3_gb_we",   bus.gb_we,    0);
    chk("wr_T3_gb_re",   bus.gb_re,    0);
    chk("wr_a_rdata",    bus.a_rdata,  0);

    // B read, RD_LAT=2, data only valid at T+2
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 24'h000100;
    tick();
    chk("rd_T_gb_re",    bus.gb_re,    1);
    chk("rd_T_gb_we",    bus.gb_we,    0);
    chk("rd_T_gb_addr",  bus.gb_addr,  24'h000100);
    tick();
    chk("rd_T1_gb_re",   bus.gb_re,    0);
    chk("rd_T1_b_ack",   bus.b_ack,    0);
    tick();
    bus.gb_rdata = 32'h000000cc;
    chk("rd_T2_b_ack",   bus.b_ack,    0);
    tick();
    bus.gb_rdata = 32'h11111111;
    chk("rd_T3_b_ack",   bus.b_ack,    1);
    chk("rd_T3_a_ack",   bus.a_ack,    0);
    chk("rd_T3_b_rdata", bus.b_rdata,  32'h000000cc);
    chk("rd_T3_a_rdata", bus.a_rdata,  0);
    bus.b_req = 1'b0;
    tick();
    chk("rd_T4_b_ack",   bus.b_ack,    0);
    chk("rd_T4_b_rdata", bus.b_rdata,  32'h000000cc);

    // A read aborted by reset during WAIT
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 24'h000020;
    bus.gb_rdata = 32'h00000077;
    tick();
    chk("ab_T_gb_re",    bus.gb_re,    1);
    tick();
    rst_n = 1'b0;
    tick();
    chk_rst_outs("ab");
    rst_n = 1'b1;
    bus.a_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ab_no_a_ack", bus.a_ack, 0);
      chk("ab_no_gb_re", bus.gb_re, 0);
    end

    // Continuous contention after reset: A read vs B write
    bus.gb_rdata = 32'h5a5a0001;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 24'h000008;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 24'h00000c; bus.b_wdata = 32'h0badf00d;
    ngr = 0;
    for (int c = 0; c < 60 && ngr < 4; c++) begin
      tick();
      chk("rr_two_acks", bus.a_ack & bus.b_ack, 0);
      chk("rr_we_re",    bus.gb_we & bus.gb_re, 0);
      if (bus.a_ack) begin
        grants[ngr] = 0; ngr++;
        chk("rr_a_rdata", bus.a_rdata, 32'h5a5a0001);
      end else if (bus.b_ack) begin
        grants[ngr] = 1; ngr++;
        chk("rr_b_rdata", bus.b_rdata, 0);
      end
      if (ngr == 4) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
    end
    chk("rr_grant_cnt", ngr, 4);
    if (ngr == 4) begin
      chk("rr_g0", grants[0], 0);
      chk("rr_g1", grants[1], 1);
      chk("rr_g2", grants[2], 0);
      chk("rr_g3", grants[3], 1);
    end
    tick(); tick();
    chk("end_gb_we", bus.gb_we, 0);
    chk("end_gb_re", bus.gb_re, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
